// File: rtl/t_sram_responder_if.sv
// T-row SRAM streaming bus between the PE-array data processor and the responder.
// The master side issues requests, write-back sends and the end-of-computation init pulse.
interface t_sram_responder_if #(
   parameter int SRAM_WORD = 83
) ();
   logic                 i_sram_request;
   logic [SRAM_WORD-1:0] o_request_data;
   logic                 i_sram_send;
   logic [SRAM_WORD-1:0] i_send_data;
   logic                 i_sram_init;

   modport master (
      output i_sram_request,
      output i_sram_send,
      output i_send_data,
      output i_sram_init,
      input  o_request_data
   );

   modport slave (
      input  i_sram_request,
      input  i_sram_send,
      input  i_send_data,
      input  i_sram_init,
      output o_request_data
   );
endinterface

// File: rtl/t_sram_responder.sv
// Circular word store that serves one preloaded T row and takes processed words back.
// Optional sticky overrun/length flag o_error is built with T_SRAM_OVERRUN_CHECK_EN.
module t_sram_responder #(
   parameter int V_E_F_BIT      = 10,
   parameter int T_PER_WORD     = 4,
   parameter int HEADER_BIT     = 3,
   parameter int MAX_T_SIZE_LOG = 10,
   parameter int DEPTH          = 256
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [MAX_T_SIZE_LOG-1:0] i_T_size,
   input  logic                      i_load_valid,
   input  logic [1:0]                i_load_t,
   input  logic                      i_load_last,
   input  logic                      i_start,
   output logic                      o_busy,
`ifdef T_SRAM_OVERRUN_CHECK_EN
   output logic                      o_error,
`endif
   t_sram_responder_if.slave         bus
);
   localparam int BIT_P_GROUP = 2 + 2 * (V_E_F_BIT - 1);
   localparam int DATA_W      = BIT_P_GROUP * T_PER_WORD;
   localparam int SRAM_WORD   = HEADER_BIT + DATA_W;
   localparam int LOG_TPW     = $clog2(T_PER_WORD);
   localparam int SW          = (LOG_TPW > 0) ? LOG_TPW : 1;
   localparam int PW          = $clog2(DEPTH);
   localparam int AW          = PW + 1;
   localparam int NW          = MAX_T_SIZE_LOG + 1;
   localparam int CW          = HEADER_BIT - 1;

   typedef enum logic {S_IDLE, S_RUN} state_e;

   state_e                state_q, state_d;
   logic [DATA_W-1:0]     stage_q, stage_d;
   logic [SW-1:0]         slot_q, slot_d;
   logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
   logic [AW-1:0]         avail_q, avail_d;
   logic                  pend_q, pend_d;
   logic [NW-1:0]         nw_q, nw_d;
   logic [SW-1:0]         lrem_q, lrem_d;
   logic [SRAM_WORD-1:0]  resp_q, resp_d;
   logic                  err_q, err_d;

   logic [DATA_W-1:0]     mem_q [DEPTH];
   logic                  mem_we;
   logic [PW-1:0]         mem_wa;
   logic [DATA_W-1:0]     mem_wd;

   logic [DATA_W-1:0]     stage_ins;
   logic [DATA_W-1:0]     rdata;
   logic [NW-1:0]         w_new;
   logic [CW-1:0]         cnt;
   logic                  rd_last, wr_last;
   logic                  req_eff, pend_now, fire, wr_ok;
   logic                  unused_hdr;

   assign unused_hdr = ^bus.i_send_data[SRAM_WORD-1:DATA_W];
   assign o_busy = (state_q == S_RUN);
   assign bus.o_request_data = resp_q;
`ifdef T_SRAM_OVERRUN_CHECK_EN
   assign o_error = err_q;
`endif

   assign rd_last = (int'(rd_ptr_q) == int'(nw_q) - 1);
   assign wr_last = (int'(wr_ptr_q) == int'(nw_q) - 1);
   assign w_new = ({1'b0, i_T_size} + NW'(T_PER_WORD - 1)) >> LOG_TPW;
   assign cnt = (rd_last && lrem_q != '0) ? CW'(lrem_q) : '0;
   // An empty store can only be serving the word being sent this cycle
   assign rdata = (avail_q == '0) ? bus.i_send_data[DATA_W-1:0]
                                  : mem_q[rd_ptr_q];

   always_comb begin
      stage_ins = stage_q;
      for (int j = 0; j < T_PER_WORD; j++) begin
         if (SW'(j) == slot_q) begin
            stage_ins[BIT_P_GROUP*(T_PER_WORD-j)-1 -: BIT_P_GROUP] =
               {i_load_t, {(BIT_P_GROUP-2){1'b0}}};
         end
      end
   end

   always_comb begin
      state_d  = state_q;
      stage_d  = stage_q;
      slot_d   = slot_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      avail_d  = avail_q;
      pend_d   = pend_q;
      nw_d     = nw_q;
      lrem_d   = lrem_q;
      resp_d   = '0;
      err_d    = err_q;
      mem_we   = 1'b0;
      mem_wa   = wr_ptr_q;
      mem_wd   = bus.i_send_data[DATA_W-1:0];
      req_eff  = 1'b0;
      pend_now = 1'b0;
      fire     = 1'b0;
      wr_ok    = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            if (i_start) begin
               state_d  = S_RUN;
               rd_ptr_d = '0;
               wr_ptr_d = '0;
               nw_d     = w_new;
               lrem_d   = i_T_size[SW-1:0] & SW'(T_PER_WORD - 1);
               if (int'(avail_q) != int'(w_new)) err_d = 1'b1;
            end else if (i_load_valid) begin
               stage_d = stage_ins;
               slot_d  = slot_q + 1'b1;
               if (slot_q == SW'(T_PER_WORD - 1) || i_load_last) begin
                  stage_d = '0;
                  slot_d  = '0;
                  if (avail_q < AW'(DEPTH)) begin
                     mem_we   = 1'b1;
                     mem_wd   = stage_ins;
                     wr_ptr_d = wr_ptr_q + 1'b1;
                     avail_d  = avail_q + 1'b1;
                  end
               end
            end
         end
         S_RUN: begin
            // The word on the bus this cycle has not been seen by the requester yet
            req_eff  = bus.i_sram_request & ~resp_q[SRAM_WORD-1];
            pend_now = pend_q | req_eff;
            fire     = pend_now & ((avail_q != '0) | bus.i_sram_send);
            wr_ok    = bus.i_sram_send &
                       ((int'(avail_q) != int'(nw_q)) | fire);
            pend_d   = pend_now & ~fire;
            if (fire) begin
               resp_d   = {1'b1, cnt, rdata};
               rd_ptr_d = rd_last ? '0 : rd_ptr_q + 1'b1;
            end
            if (wr_ok) begin
               mem_we   = 1'b1;
               wr_ptr_d = wr_last ? '0 : wr_ptr_q + 1'b1;
            end
            if (bus.i_sram_send && !wr_ok) err_d = 1'b1;
            avail_d = avail_q + AW'(wr_ok) - AW'(fire);
         end
         default: state_d = S_IDLE;
      endcase

      if (bus.i_sram_init) begin
         state_d  = S_IDLE;
         stage_d  = '0;
         slot_d   = '0;
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         avail_d  = '0;
         pend_d   = 1'b0;
         resp_d   = '0;
         mem_we   = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= S_IDLE;
         stage_q  <= '0;
         slot_q   <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         avail_q  <= '0;
         pend_q   <= 1'b0;
         nw_q     <= '0;
         lrem_q   <= '0;
         resp_q   <= '0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         stage_q  <= stage_d;
         slot_q   <= slot_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         avail_q  <= avail_d;
         pend_q   <= pend_d;
         nw_q     <= nw_d;
         lrem_q   <= lrem_d;
         resp_q   <= resp_d;
         err_q    <= err_d;
      end
   end

   always_ff @(posedge clk) begin
      if (mem_we) mem_q[mem_wa] <= mem_wd;
   end
endmodule

// File: tb/tb_t_sram_responder.sv
// Directed bench for t_sram_responder: load, serve, write-back bypass, pacing, init, reset.
// Overrun checks on o_error are compiled in with T_SRAM_OVERRUN_CHECK_EN.
module tb_t_sram_responder;
   localparam int SRAM_WORD = 83;

   logic       clk = 1'b0;
   logic       rst;
   logic [9:0] t_size;
   logic       load_valid;
   logic [1:0] load_t;
   logic       load_last;
   logic       start;
   logic       busy;
`ifdef T_SRAM_OVERRUN_CHECK_EN
   logic       err;
`endif

   int n_tests = 0;
   int n_fail  = 0;
   int n_resp;
   logic [SRAM_WORD-1:0] last_resp;

   localparam logic [79:0] D_A5 = 80'h0123_4567_89AB_CDEF_00A5;
   localparam logic [79:0] D_2  = 80'hFEDC_BA98_7654_3210_5A5A;
   localparam logic [SRAM_WORD-1:0] W0 =
      {1'b1, 2'd0, 2'd0, 18'd0, 2'd1, 18'd0, 2'd2, 18'd0, 2'd3, 18'd0};
   localparam logic [SRAM_WORD-1:0] W1 =
      {1'b1, 2'd2, 2'd0, 18'd0, 2'd1, 18'd0, 40'd0};
   localparam logic [SRAM_WORD-1:0] W3210 =
      {1'b1, 2'd0, 2'd3, 18'd0, 2'd2, 18'd0, 2'd1, 18'd0, 2'd0, 18'd0};

   t_sram_responder_if #(.SRAM_WORD(SRAM_WORD)) bus ();

   t_sram_responder dut (
      .clk          (clk),
      .rst          (rst),
      .i_T_size     (t_size),
      .i_load_valid (load_valid),
      .i_load_t     (load_t),
      .i_load_last  (load_last),
      .i_start      (start),
      .o_busy       (busy),
`ifdef T_SRAM_OVERRUN_CHECK_EN
      .o_error      (err),
`endif
      .bus          (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag,
                        input logic [SRAM_WORD-1:0] got,
                        input logic [SRAM_WORD-1:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic load_sym(input logic [1:0] t, input logic last);
      load_valid = 1'b1;
      load_t     = t;
      load_last  = last;
      step();
      load_valid = 1'b0;
      load_last  = 1'b0;
   endtask

   task automatic start_row(input logic [9:0] n);
      t_size = n;
      start  = 1'b1;
      step();
      start  = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      t_size = '0;
      load_valid = 1'b0;
      load_t = '0;
      load_last = 1'b0;
      start = 1'b0;
      bus.i_sram_request = 1'b0;
      bus.i_sram_send = 1'b0;
      bus.i_send_data = '0;
      bus.i_sram_init = 1'b0;
      step();
      step();
      rst = 1'b0;
      check("rst_busy", SRAM_WORD'(busy), '0);
      check("rst_data", bus.o_request_data, '0);
`ifdef T_SRAM_OVERRUN_CHECK_EN
      check("rst_err", SRAM_WORD'(err), '0);
`endif

      // T=6: two words, second one partial with two groups
      for (int i = 0; i < 6; i++) load_sym(2'(i % 4), i == 5);
      start_row(10'd6);
      check("busy_up", SRAM_WORD'(busy), SRAM_WORD'(1));
      bus.i_sram_request = 1'b1;
      step();
      bus.i_sram_request = 1'b0;
      check("word0", bus.o_request_data, W0);
      step();
      check("word0_1cyc", bus.o_request_data, '0);
      bus.i_sram_request = 1'b1;
      step();
      bus.i_sram_request = 1'b0;
      check("word1_tail", bus.o_request_data, W1);

      // Store empty: held request waits, then a send is bypassed straight out
      bus.i_sram_request = 1'b1;
      step();
      check("empty_wait0", bus.o_request_data, '0);
      step();
      check("empty_wait1", bus.o_request_data, '0);
      bus.i_sram_request = 1'b0;
      bus.i_sram_send = 1'b1;
      bus.i_send_data = {3'b111, D_A5};
      step();
      bus.i_sram_send = 1'b0;
      check("bypass", bus.o_request_data, {1'b1, 2'd0, D_A5});

      bus.i_sram_send = 1'b1;
      bus.i_send_data = {3'b010, D_2};
      step();
      bus.i_sram_send = 1'b0;
      bus.i_sram_request = 1'b1;
      step();
      bus.i_sram_request = 1'b0;
      check("wb_tail", bus.o_request_data, {1'b1, 2'd2, D_2});

      // Init with a pending request
      bus.i_sram_request = 1'b1;
      step();
      bus.i_sram_request = 1'b0;
      check("pend_none", bus.o_request_data, '0);
      bus.i_sram_init = 1'b1;
      step();
      bus.i_sram_init = 1'b0;
      check("init_busy", SRAM_WORD'(busy), '0);
      check("init_data", bus.o_request_data, '0);
      step();
      check("init_quiet", bus.o_request_data, '0);

      // Fresh row of 3 full words, request held 6 cycles
      for (int i = 0; i < 12; i++) load_sym(2'(i % 4), i == 11);
      start_row(10'd12);
      check("busy_re", SRAM_WORD'(busy), SRAM_WORD'(1));
      n_resp = 0;
      last_resp = '0;
      bus.i_sram_request = 1'b1;
      for (int k = 0; k < 6; k++) begin
         step();
         if (bus.o_request_data[SRAM_WORD-1]) begin
            n_resp++;
            last_resp = bus.o_request_data;
         end
      end
      bus.i_sram_request = 1'b0;
      check("pace_count", SRAM_WORD'(n_resp), SRAM_WORD'(3));
      check("pace_last", last_resp, W0);

      // Asynchronous reset mid-run
      bus.i_sram_request = 1'b1;
      step();
      rst = 1'b1;
      #2;
      check("arst_busy", SRAM_WORD'(busy), '0);
      check("arst_data", bus.o_request_data, '0);
      step();
      rst = 1'b0;
      step();
      bus.i_sram_request = 1'b0;
      check("arst_req", bus.o_request_data, '0);
      check("arst_idle", SRAM_WORD'(busy), '0);

      // Single-word row: an extra send must not overwrite the stored word
      for (int i = 0; i < 4; i++) load_sym(2'(3 - i), i == 3);
      start_row(10'd4);
`ifdef T_SRAM_OVERRUN_CHECK_EN
      check("len_ok_err", SRAM_WORD'(err), '0);
`endif
      bus.i_sram_send = 1'b1;
      bus.i_send_data = {3'b000, D_A5};
      step();
      bus.i_sram_send = 1'b0;
`ifdef T_SRAM_OVERRUN_CHECK_EN
      check("ovr_err", SRAM_WORD'(err), SRAM_WORD'(1));
`endif
      bus.i_sram_request = 1'b1;
      step();
      bus.i_sram_request = 1'b0;
      check("ovr_keep", bus.o_request_data, W3210);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
